// File: rtl/mac_driver.sv
// Operand sequencer / result collector for the single-shot 4x4 MAC.
// Optional per-transaction watchdog enabled by defining MAC_DRV_TIMEOUT_EN.
module mac_driver #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ld_valid,
  input  logic [3:0]                 ld_a,
  input  logic [3:0]                 ld_b,
  output logic                       ld_ready,
  input  logic                       clr,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     count,
  output logic [3:0]                 mac_in1,
  output logic [3:0]                 mac_in2,
  output logic                       mac_in_valid,
  input  logic [9:0]                 mac_out,
  input  logic                       mac_out_valid,
  input  logic [$clog2(DEPTH)-1:0]   res_rd_addr,
  output logic [9:0]                 res_rd_data,
  output logic [15:0]                acc,
  output logic                       timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      TIMEOUT < 1 || TIMEOUT > 31) begin : g_bad_param
    $error("mac_driver: illegal DEPTH or TIMEOUT");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_ptr;
  logic [15:0]     r_acc;
  logic [3:0]      r_mac_in1;
  logic [3:0]      r_mac_in2;
  logic            r_mac_in_valid;
  logic            r_done;
  logic            r_timeout_err;
  logic [7:0]      r_op  [DEPTH];
  logic [9:0]      r_res [DEPTH];
`ifdef MAC_DRV_TIMEOUT_EN
  logic [4:0]      r_wcnt;
`endif

  logic            w_ld_ready;
  logic            w_ld_fire;
  logic            w_last;

  assign w_ld_ready = (r_state == IDLE) && (r_count < CW'(DEPTH));
  assign w_ld_fire  = w_ld_ready && ld_valid && !clr;
  assign w_last     = ({1'b0, r_ptr} == (r_count - CW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_ptr          <= '0;
      r_acc          <= '0;
      r_mac_in1      <= '0;
      r_mac_in2      <= '0;
      r_mac_in_valid <= 1'b0;
      r_done         <= 1'b0;
      r_timeout_err  <= 1'b0;
`ifdef MAC_DRV_TIMEOUT_EN
      r_wcnt         <= '0;
`endif
    end else begin
      r_mac_in_valid <= 1'b0;
      r_mac_in1      <= '0;
      r_mac_in2      <= '0;
      case (r_state)
        IDLE: begin
          if (clr) begin
            r_count       <= '0;
            r_acc         <= '0;
            r_timeout_err <= 1'b0;
          end else begin
            if (w_ld_fire) r_count <= r_count + CW'(1);
            if (start) begin
              r_acc   <= '0;
              r_ptr   <= '0;
              r_state <= (r_count != '0) ? ISSUE : DONE;
            end
          end
        end
        ISSUE: begin
          r_mac_in_valid <= 1'b1;
          r_mac_in1      <= r_op[r_ptr][7:4];
          r_mac_in2      <= r_op[r_ptr][3:0];
`ifdef MAC_DRV_TIMEOUT_EN
          r_wcnt         <= '0;
`endif
          r_state        <= WAIT;
        end
        WAIT: begin
          if (mac_out_valid) begin
            r_acc <= r_acc + {6'd0, mac_out};
            if (w_last) begin
              r_state <= DONE;
            end else begin
              r_ptr   <= r_ptr + AW'(1);
              r_state <= ISSUE;
            end
          end
`ifdef MAC_DRV_TIMEOUT_EN
          else if (r_wcnt == 5'(TIMEOUT - 1)) begin
            r_timeout_err <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_wcnt <= r_wcnt + 5'd1;
          end
`endif
        end
        // DONE spans two cycles so busy stays high until the done pulse ends
        DONE: begin
          if (!r_done) begin
            r_done <= 1'b1;
          end else begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Buffers hold data only; count==0 after reset makes their contents irrelevant
  always_ff @(posedge clk) begin
    if (w_ld_fire) r_op[r_count[AW-1:0]] <= {ld_a, ld_b};
    if (r_state == WAIT && mac_out_valid) r_res[r_ptr] <= mac_out;
  end

  assign ld_ready     = w_ld_ready;
  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign count        = r_count;
  assign mac_in1      = r_mac_in1;
  assign mac_in2      = r_mac_in2;
  assign mac_in_valid = r_mac_in_valid;
  assign res_rd_data  = r_res[res_rd_addr];
  assign acc          = r_acc;
`ifdef MAC_DRV_TIMEOUT_EN
  assign timeout_err  = r_timeout_err;
`else
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mac_driver.sv
// Scoreboard bench for mac_driver with a 4-edge behavioural MAC model.
module tb_mac_driver;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid, clr, start;
  logic [3:0]  ld_a, ld_b;
  logic        ld_ready, busy, done;
  logic [3:0]  count;
  logic [3:0]  mac_in1, mac_in2;
  logic        mac_in_valid;
  logic [9:0]  mac_out;
  logic        mac_out_valid;
  logic [2:0]  res_rd_addr;
  logic [9:0]  res_rd_data;
  logic [15:0] acc;
  logic        timeout_err;

  always #5 clk = ~clk;

  mac_driver #(.DEPTH(DEPTH), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_a(ld_a), .ld_b(ld_b),
    .ld_ready(ld_ready), .clr(clr), .start(start), .busy(busy), .done(done),
    .count(count), .mac_in1(mac_in1), .mac_in2(mac_in2),
    .mac_in_valid(mac_in_valid), .mac_out(mac_out), .mac_out_valid(mac_out_valid),
    .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data), .acc(acc),
    .timeout_err(timeout_err)
  );

  // MAC model: result strobe sampled 4 edges after in_valid is sampled
  logic       mac_en = 1'b1;
  logic       spur = 1'b0;
  logic [9:0] spur_d = '0;
  logic [3:0] pv;
  logic [9:0] pd [4];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
    end else begin
      pv    <= {pv[2:0], mac_in_valid & mac_en};
      pd[0] <= 10'(mac_in1) * 10'(mac_in2);
      pd[1] <= pd[0];
      pd[2] <= pd[1];
      pd[3] <= pd[2];
    end
  end
  assign mac_out_valid = pv[3] | spur;
  assign mac_out       = spur ? spur_d : pd[3];

  int n_tests = 0;
  int n_fail  = 0;
  int n_iss   = 0;
  int n_done  = 0;
  logic [7:0] exp_q [$];
  logic [3:0] m_a [DEPTH];
  logic [3:0] m_b [DEPTH];
  int m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (mac_in_valid) begin
        n_iss++;
        if (exp_q.size() > 0) chk("issue_ops", 32'({mac_in1, mac_in2}), 32'(exp_q.pop_front()));
        else                  chk("issue_unexpected", 32'(1), 32'(0));
      end
      if (done) n_done++;
    end
  end

  task automatic load(input logic [3:0] a, input logic [3:0] b);
    ld_a = a; ld_b = b; ld_valid = 1'b1;
    chk("ld_ready", 32'(ld_ready), 32'(m_cnt < DEPTH));
    if (m_cnt < DEPTH) begin
      m_a[m_cnt] = a; m_b[m_cnt] = b; m_cnt++;
    end
    tick();
    ld_valid = 1'b0;
    chk("count", 32'(count), 32'(m_cnt));
  endtask

  task automatic clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_cnt = 0;
    chk("clr_count", 32'(count), 32'(0));
    chk("clr_acc", 32'(acc), 32'(0));
  endtask

  task automatic run_batch(input logic [15:0] exp_acc, input bit disturb);
    int i0 = n_iss;
    int d0 = n_done;
    bit got = 1'b0;
    for (int i = 0; i < m_cnt; i++) exp_q.push_back({m_a[i], m_b[i]});
    start = 1'b1;
    tick();
    start = 1'b0;
    if (disturb) begin
      spur_d = 10'd777; spur = 1'b1;
      tick();
      spur = 1'b0;
      tick(); tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int k = 0; k < 6 * m_cnt + 20; k++) begin
      if (n_done != d0) begin got = 1'b1; break; end
      tick();
    end
    chk("done_seen", 32'(got), 32'(1));
    tick(); tick();
    chk("busy_after", 32'(busy), 32'(0));
    chk("done_pulses", 32'(n_done - d0), 32'(1));
    chk("issue_count", 32'(n_iss - i0), 32'(m_cnt));
    chk("acc", 32'(acc), 32'(exp_acc));
    for (int i = 0; i < m_cnt; i++) begin
      res_rd_addr = 3'(i);
      #1;
      chk("res", 32'(res_rd_data), 32'(m_a[i]) * 32'(m_b[i]));
    end
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    int i0, d0;
    bit got;
    rst_n = 1'b0; ld_valid = 1'b0; clr = 1'b0; start = 1'b0;
    ld_a = '0; ld_b = '0; res_rd_addr = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_in_valid", 32'(mac_in_valid), 32'(0));
    chk("rst_ops", 32'({mac_in1, mac_in2}), 32'(0));
    chk("rst_acc", 32'(acc), 32'(0));
    chk("rst_terr", 32'(timeout_err), 32'(0));
    chk("rst_ld_ready", 32'(ld_ready), 32'(1));

    // basic three-entry batch
    load(4'd3, 4'd4); load(4'd15, 4'd15); load(4'd0, 4'd9);
    run_batch(16'd237, 1'b0);

    // spurious result strobe in IDLE
    spur_d = 10'd500; spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("idle_spur_acc", 32'(acc), 32'(237));
    res_rd_addr = 3'd0; #1;
    chk("idle_spur_res", 32'(res_rd_data), 32'(12));

    // rerun retained buffer with spurious strobe in ISSUE and start mid-batch
    run_batch(16'd237, 1'b1);

    // full buffer
    clear();
    for (int i = 0; i < 9; i++) load(4'd15, 4'd15);
    chk("full_ld_ready", 32'(ld_ready), 32'(0));
    run_batch(16'd1800, 1'b0);

    // empty batch
    clear();
    i0 = n_iss; d0 = n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("empty_done", 32'(done), 32'(1));
    tick(); tick();
    chk("empty_pulses", 32'(n_done - d0), 32'(1));
    chk("empty_issues", 32'(n_iss - i0), 32'(0));
    chk("empty_acc", 32'(acc), 32'(0));
    chk("empty_busy", 32'(busy), 32'(0));

    // unresponsive MAC
    load(4'd2, 4'd2);
    exp_q.push_back({4'd2, 4'd2});
    mac_en = 1'b0;
    d0 = n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef MAC_DRV_TIMEOUT_EN
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (n_done != d0) begin got = 1'b1; break; end
      tick();
    end
    chk("to_done", 32'(got), 32'(1));
    chk("to_err", 32'(timeout_err), 32'(1));
    chk("to_acc", 32'(acc), 32'(0));
    tick(); tick();
    mac_en = 1'b1;
    clear();
    chk("to_err_clr", 32'(timeout_err), 32'(0));
`else
    for (int k = 0; k < 100; k++) tick();
    chk("hang_busy", 32'(busy), 32'(1));
    chk("hang_terr", 32'(timeout_err), 32'(0));
    chk("hang_done", 32'(n_done - d0), 32'(0));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mac_en = 1'b1;
    m_cnt = 0;
    exp_q.delete();
    tick();
`endif

    // reset during WAIT of entry 2
    clear();
    load(4'd1, 4'd2); load(4'd2, 4'd3); load(4'd3, 4'd4);
    for (int i = 0; i < m_cnt; i++) exp_q.push_back({m_a[i], m_b[i]});
    i0 = n_iss;
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (n_iss - i0 == 2) begin got = 1'b1; break; end
      tick();
    end
    chk("mid_second_issue", 32'(got), 32'(1));
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_count", 32'(count), 32'(0));
    chk("mid_rst_acc", 32'(acc), 32'(0));
    chk("mid_rst_in_valid", 32'(mac_in_valid), 32'(0));
    chk("mid_rst_ld_ready", 32'(ld_ready), 32'(1));
    exp_q.delete();
    m_cnt = 0;
    tick();
    rst_n = 1'b1;
    tick();
    load(4'd1, 4'd2); load(4'd2, 4'd3); load(4'd3, 4'd4);
    run_batch(16'd20, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
